// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one 4-bit combinational ALU between two requesters.
// Round-robin arbitration, one transaction in flight, registered responses.

// 4-bit combinational ALU. Opcode 3'b111 is unsupported and yields zero.
module alu (
  input  logic [2:0] op,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] y
);

  // Opcode decode; ADD/SUB wrap modulo 16 with no carry/borrow out
  always_comb begin
    y = 4'd0;
    case (op)
      3'b000:  y = a + b;
      3'b001:  y = a - b;
      3'b010:  y = a & b;
      3'b011:  y = a | b;
      3'b100:  y = a ^ b;
      3'b101:  y = a;
      3'b110:  y = b;
      default: y = 4'd0;
    endcase
  end

endmodule

module alu_arbiter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_a,
  input  logic [3:0]       req0_b,
  input  logic [2:0]       req0_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [3:0]       rsp0_data,
  output logic             rsp0_err,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_a,
  input  logic [3:0]       req1_b,
  input  logic [2:0]       req1_op,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [3:0]       rsp1_data,
  output logic             rsp1_err,
  output logic             busy,
  output logic [CNT_W-1:0] done_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             id_q, id_d;
  logic [3:0]       a_q, a_d;
  logic [3:0]       b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic [3:0]       data_q, data_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] done_cnt_q, done_cnt_d;

  logic             winner;
  logic             hs0, hs1;
  logic             rsp_hs;
  logic [3:0]       alu_y;

  // ALU sees only the latched operands, never the live request inputs
  alu u_alu (
    .op (op_q),
    .a  (a_q),
    .b  (b_q),
    .y  (alu_y)
  );

  // Winner selection: a lone requester wins; on a tie the one not served last wins
  always_comb begin
    if (req0_valid && req1_valid) winner = ~last_grant_q;
    else                          winner = req1_valid;
  end

  assign req0_ready = (state_q == S_IDLE) && req0_valid && (winner == 1'b0);
  assign req1_ready = (state_q == S_IDLE) && req1_valid && (winner == 1'b1);
  assign hs0        = req0_valid && req0_ready;
  assign hs1        = req1_valid && req1_ready;

  assign rsp0_valid = (state_q == S_RESP) && (id_q == 1'b0);
  assign rsp1_valid = (state_q == S_RESP) && (id_q == 1'b1);
  // Only the granted channel's ready can complete the response
  assign rsp_hs     = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);

  // Result/err are shown only on the channel currently presenting a response
  assign rsp0_data  = rsp0_valid ? data_q : 4'd0;
  assign rsp1_data  = rsp1_valid ? data_q : 4'd0;
  assign rsp0_err   = rsp0_valid & err_q;
  assign rsp1_err   = rsp1_valid & err_q;

  assign busy       = (state_q != S_IDLE);
  assign done_cnt   = done_cnt_q;

  // Next-state logic for the IDLE -> EXEC -> RESP transaction cycle
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    data_d       = data_q;
    err_d        = err_q;
    done_cnt_d   = done_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (hs0) begin
          a_d     = req0_a;
          b_d     = req0_b;
          op_d    = req0_op;
          id_d    = 1'b0;
          state_d = S_EXEC;
        end else if (hs1) begin
          a_d     = req1_a;
          b_d     = req1_b;
          op_d    = req1_op;
          id_d    = 1'b1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        data_d  = alu_y;
        err_d   = (op_q == 3'b111);
        state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_hs) begin
          last_grant_d = id_q;
          done_cnt_d   = done_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset discards any transaction in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      a_q          <= 4'd0;
      b_q          <= 4'd0;
      op_q         <= 3'd0;
      data_q       <= 4'd0;
      err_q        <= 1'b0;
      done_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      data_q       <= data_d;
      err_q        <= err_d;
      done_cnt_q   <= done_cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed steps plus randomized traffic
// checked against a transaction-level reference model.
module tb_alu_arbiter;

  logic       clk;
  logic       rst;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [3:0] req_a [2];
  logic [3:0] req_b [2];
  logic [2:0] req_op [2];
  logic [1:0] rsp_valid;
  logic [1:0] rsp_ready;
  logic [3:0] rsp_data [2];
  logic [1:0] rsp_err;
  logic       busy;
  logic [7:0] done_cnt;

  int checks;
  int failures;
  int exp_cnt;
  int last_served;

  alu_arbiter #(.CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req_valid[0]),
    .req0_ready (req_ready[0]),
    .req0_a     (req_a[0]),
    .req0_b     (req_b[0]),
    .req0_op    (req_op[0]),
    .rsp0_valid (rsp_valid[0]),
    .rsp0_ready (rsp_ready[0]),
    .rsp0_data  (rsp_data[0]),
    .rsp0_err   (rsp_err[0]),
    .req1_valid (req_valid[1]),
    .req1_ready (req_ready[1]),
    .req1_a     (req_a[1]),
    .req1_b     (req_b[1]),
    .req1_op    (req_op[1]),
    .rsp1_valid (rsp_valid[1]),
    .rsp1_ready (rsp_ready[1]),
    .rsp1_data  (rsp_data[1]),
    .rsp1_err   (rsp_err[1]),
    .busy       (busy),
    .done_cnt   (done_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Reference ALU from the opcode table, plain integer arithmetic
  function automatic logic [3:0] ref_alu(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    int ia, ib, r;
    ia = a;
    ib = b;
    case (op)
      3'd0:    r = (ia + ib) % 16;
      3'd1:    r = (ia - ib + 16) % 16;
      3'd2:    r = ia & ib;
      3'd3:    r = ia | ib;
      3'd4:    r = ia ^ ib;
      3'd5:    r = ia;
      3'd6:    r = ib;
      default: r = 0;
    endcase
    return r[3:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs applied afterwards settle before sampling
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    #1;
    exp_cnt     = 0;
    last_served = 1;
    chk("rst_busy", busy, 0);
    chk("rst_done_cnt", done_cnt, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp0_data", rsp_data[0], 0);
    chk("rst_rsp1_data", rsp_data[1], 0);
  endtask

  // One requester alone; bp = cycles of response backpressure
  task automatic serve(input int who, input logic [3:0] a, input logic [3:0] b,
                       input logic [2:0] op, input int bp);
    int o;
    logic [3:0] ed;
    logic ee;
    o  = 1 - who;
    ed = ref_alu(op, a, b);
    ee = (op == 3'b111);
    req_a[who] = a; req_b[who] = b; req_op[who] = op; req_valid[who] = 1'b1;
    #1;
    chk("req_ready_win", req_ready[who], 1);
    chk("req_ready_other", req_ready[o], 0);
    chk("busy_idle", busy, 0);
    cyc();
    // Scramble the request inputs: the latched copy must be used
    req_valid[who] = 1'b0;
    req_a[who] = 4'($urandom); req_b[who] = 4'($urandom); req_op[who] = 3'($urandom);
    req_valid[o] = 1'b1;
    #1;
    chk("exec_busy", busy, 1);
    chk("exec_rsp_valid", rsp_valid, 0);
    chk("exec_req_ready", req_ready, 0);
    cyc();
    chk("resp_valid_own", rsp_valid[who], 1);
    chk("resp_valid_other", rsp_valid[o], 0);
    chk("resp_data", rsp_data[who], ed);
    chk("resp_err", rsp_err[who], ee);
    for (int i = 0; i < bp; i++) begin
      rsp_ready[o] = 1'b1;
      cyc();
      chk("bp_valid", rsp_valid[who], 1);
      chk("bp_data", rsp_data[who], ed);
      chk("bp_err", rsp_err[who], ee);
      chk("bp_busy", busy, 1);
      chk("bp_req_ready", req_ready, 0);
      chk("bp_done_cnt", done_cnt, exp_cnt[7:0]);
    end
    rsp_ready[o] = 1'b0;
    req_valid[o] = 1'b0;
    rsp_ready[who] = 1'b1;
    cyc();
    rsp_ready[who] = 1'b0;
    exp_cnt++;
    last_served = who;
    #1;
    chk("done_rsp_valid", rsp_valid, 0);
    chk("done_busy", busy, 0);
    chk("done_cnt", done_cnt, exp_cnt[7:0]);
    $display("txn who=%0d op=%0d a=%0d b=%0d data=%0d err=%0d bp=%0d cnt=%0d",
             who, op, a, b, ed, ee, bp, exp_cnt);
  endtask

  // Both requesters valid, both response channels ready; round-robin winner
  task automatic both_round(input logic [3:0] a0, input logic [3:0] b0, input logic [2:0] op0,
                            input logic [3:0] a1, input logic [3:0] b1, input logic [2:0] op1);
    int w;
    logic [3:0] ed;
    w = 1 - last_served;
    ed = (w == 0) ? ref_alu(op0, a0, b0) : ref_alu(op1, a1, b1);
    req_a[0] = a0; req_b[0] = b0; req_op[0] = op0;
    req_a[1] = a1; req_b[1] = b1; req_op[1] = op1;
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    #1;
    chk("rr_ready_win", req_ready[w], 1);
    chk("rr_ready_lose", req_ready[1-w], 0);
    cyc();
    chk("rr_exec_busy", busy, 1);
    cyc();
    chk("rr_valid_win", rsp_valid[w], 1);
    chk("rr_valid_lose", rsp_valid[1-w], 0);
    chk("rr_data", rsp_data[w], ed);
    cyc();
    exp_cnt++;
    last_served = w;
    chk("rr_done_cnt", done_cnt, exp_cnt[7:0]);
    chk("rr_rsp_valid_clear", rsp_valid, 0);
    $display("txn rr winner=%0d data=%0d cnt=%0d", w, ed, exp_cnt);
  endtask

  initial begin
    checks = 0; failures = 0; exp_cnt = 0; last_served = 1;
    rst = 1'b1;
    req_valid = 2'b00; rsp_ready = 2'b00;
    for (int i = 0; i < 2; i++) begin
      req_a[i] = 4'd0; req_b[i] = 4'd0; req_op[i] = 3'd0;
    end
    do_reset();

    // Single request: 3+2
    serve(0, 4'd3, 4'd2, 3'b000, 0);

    // Tie after reset: req0 first, then alternate
    do_reset();
    both_round(4'd3, 4'd2, 3'b000, 4'd3, 4'd2, 3'b001);
    both_round(4'd3, 4'd2, 3'b000, 4'd3, 4'd2, 3'b001);
    both_round(4'd3, 4'd2, 3'b000, 4'd3, 4'd2, 3'b001);
    both_round(4'd3, 4'd2, 3'b000, 4'd3, 4'd2, 3'b001);
    req_valid = 2'b00; rsp_ready = 2'b00;

    // Wrap and logic cases
    serve(0, 4'd15, 4'd1, 3'b000, 0);
    serve(1, 4'd2, 4'd3, 3'b001, 0);
    serve(0, 4'b1010, 4'b0110, 3'b010, 0);
    serve(1, 4'b1010, 4'b0110, 3'b011, 0);
    serve(0, 4'b1010, 4'b0110, 3'b100, 0);
    serve(1, 4'd9, 4'd4, 3'b101, 0);
    serve(0, 4'd9, 4'd4, 3'b110, 0);

    // Unsupported opcode, then a valid one clears err
    serve(1, 4'd7, 4'd7, 3'b111, 0);
    serve(1, 4'd7, 4'd7, 3'b000, 0);

    // Backpressure on requester 1
    serve(1, 4'd6, 4'd5, 3'b001, 4);

    // Reset during EXEC discards the transaction
    req_a[0] = 4'd4; req_b[0] = 4'd4; req_op[0] = 3'b000; req_valid[0] = 1'b1;
    cyc();
    req_valid[0] = 1'b0;
    #1;
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    exp_cnt = 0; last_served = 1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done_cnt", done_cnt, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("mid_rst_no_rsp", rsp_valid, 0);
    end
    serve(0, 4'd1, 4'd2, 3'b000, 0);

    // Randomized traffic against the reference model
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 2) == 0)
        both_round(4'($urandom), 4'($urandom), 3'($urandom),
                   4'($urandom), 4'($urandom), 3'($urandom));
      else
        serve(int'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), 3'($urandom),
              int'($urandom_range(0, 3)));
      req_valid = 2'b00; rsp_ready = 2'b00;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares the single 4-bit combinational `alu` (ADD/SUB/AND/OR/XOR/pass-A/pass-B) between two independent requesters.
- Each requester issues operand/opcode transactions over a valid/ready request channel and receives a registered result over a valid/ready response channel.
- Round-robin arbitration gives fairness.
- Exactly one transaction is in flight at a time.
- The block instantiates `alu` internally and sits between client FSMs and the ALU datapath.

Parameters:
CNT_W, 8, width of the completed-transaction counter `done_cnt`

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
req0_valid  input  1  requester 0 has a transaction
req0_ready  output  1  requester 0 transaction accepted this cycle
req0_a  input  4  requester 0 operand A
req0_b  input  4  requester 0 operand B
req0_op  input  3  requester 0 opcode (ALU encoding)
rsp0_valid  output  1  result available for requester 0
rsp0_ready  input  1  requester 0 consumes result
rsp0_data  output  4  result for requester 0
rsp0_err  output  1  opcode 3'b111 (unsupported) was issued
req1_valid, req1_ready, req1_a, req1_b, req1_op  same as requester 0, for requester 1
rsp1_valid, rsp1_ready, rsp1_data, rsp1_err  same as requester 0, for requester 1
busy  output  1  state is not IDLE
done_cnt  output  CNT_W  number of completed response handshakes

Behaviour:
- Clock and reset: one clock, `clk`; reset `rst` is synchronous, active-high.
- Reset values:
  - state = IDLE; last_grant = 1, so requester 0 wins the first tie.
  - All ready/valid/err outputs = 0; rsp*_data = 0; done_cnt = 0; busy = 0.
- States: IDLE, EXEC, RESP.
- IDLE:
  - Winner selection:
    - Only one req*_valid high: that requester wins.
    - Both high: the requester != last_grant wins.
  - req*_ready is combinational: high only for the winner, and only while its valid is high. The loser's ready = 0.
  - On valid & ready:
    - Latch a, b, op and grant id into internal registers.
    - Go to EXEC.
  - No valid: remain in IDLE.
- EXEC (1 cycle):
  - The ALU is driven only from the latched registers, never live request inputs.
  - At cycle end, register data = alu result; err = (op == 3'b111).
  - For op 111, data = 0.
  - Go to RESP.
- RESP:
  - rsp*_valid high only for the granted id; the other response channel stays 0.
  - data and err are held stable until handshake.
  - On rsp*_ready:
    - Clear valid; set last_grant = id; done_cnt += 1 (wraps modulo 2^CNT_W).
    - Go to IDLE.
  - rsp*_ready on the non-granted channel is ignored.
- Latency: request handshake in cycle N → rsp_valid asserted in cycle N+2.
- Throughput: at most one transaction per 3 cycles (back-to-back when rsp_ready is held high).
- Arithmetic: 4-bit modulo; ADD/SUB wrap with no carry/borrow output. Opcodes 101/110 pass A/B respectively.
- Request inputs may change freely while not handshaking; they are ignored outside IDLE (req*_ready = 0 in EXEC and RESP).
- A requester dropping valid before being granted has no effect.
- Reset mid-transaction (EXEC or RESP): the transaction is discarded, no response is issued, and all state returns to reset values.
- busy = (state != IDLE).

Test Plan:
1. After reset, req0 a=3 b=2 op=000 alone → req0_ready same cycle; rsp0_valid two cycles later with rsp0_data=5, rsp0_err=0; done_cnt=1.
2. Both valid in the same cycle: req0 ADD 3,2 and req1 SUB 3,2, rsp ready held high → req0 served first (data 5), then req1 accepted next IDLE (data 1). With both still valid afterwards, grants alternate 0,1,0,1.
3. Wrap cases → expected data:
   - ADD 15+1 → 0
   - SUB 2-3 → 15
   - AND 1010,0110 → 0010
   - OR → 1110
   - XOR → 1100
   - op 101 → A
   - op 110 → B
4. op=111, a=7 b=7 → rsp_data=0, rsp_err=1; the next valid op clears err.
5. Backpressure: hold rsp1_ready=0 for 4 cycles in RESP → rsp1_valid and data stable, req0_ready=0 throughout, busy=1; on release, done_cnt increments once.
6. Assert rst while in EXEC → next cycle state IDLE, no rsp*_valid ever for that transaction, done_cnt=0; a subsequent request is served normally.
